// File: rtl/serial_seq_tx.sv
// Serial pattern transmitter for the sequence detectors: shifts a loaded pattern
// out MSB-first on x for repeats+1 passes and counts detector hits seen on y.
module serial_seq_tx #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4,
   parameter int REP_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] length,
   input  logic [REP_W-1:0] repeats,
   input  logic             abort,
   input  logic             y,
   output logic             x,
   output logic             x_valid,
   output logic             done,
   output logic [CNT_W-1:0] match_count
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [IDX_W-1:0] last_q, last_d;     // Le-1: index of the first bit of each pass
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [REP_W-1:0] rep_q, rep_d;       // passes still to go after the current one
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic             end_of_stream;
   logic [IDX_W-1:0] load_last;

   assign load_ready    = (state_q == IDLE);
   assign accept        = load_ready && load_valid;
   assign end_of_stream = (idx_q == '0) && (rep_q == '0);

   // Zero or oversize lengths fall back to the full pattern width.
   always_comb begin
      if (length == '0 || int'(length) > WIDTH) begin
         load_last = IDX_MAX;
      end else begin
         load_last = IDX_W'(length - 1'b1);
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load_valid) state_d = SHIFT;
         SHIFT:   if (abort || end_of_stream) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: every signal gets a hold/default value up front so no path through
   // the case leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      pat_d     = pat_q;
      last_d    = last_q;
      idx_d     = idx_q;
      rep_d     = rep_q;
      x_d       = x_q;
      x_valid_d = x_valid_q;
      done_d    = 1'b0;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               pat_d     = pattern;
               last_d    = load_last;
               idx_d     = load_last;
               rep_d     = repeats;
               cnt_d     = '0;
               x_d       = pattern[load_last];
               x_valid_d = 1'b1;
            end
         end
         SHIFT: begin
            // y is counted even on the abort edge.
            if (y && cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (abort || end_of_stream) begin
               x_d       = 1'b0;
               x_valid_d = 1'b0;
               done_d    = 1'b1;
            end else if (idx_q != '0) begin
               idx_d = idx_q - 1'b1;
               x_d   = pat_q[idx_d];
            end else begin
               rep_d = rep_q - 1'b1;
               idx_d = last_q;
               x_d   = pat_q[last_q];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pat_q     <= '0;
         last_q    <= '0;
         idx_q     <= '0;
         rep_q     <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         pat_q     <= pat_d;
         last_q    <= last_d;
         idx_q     <= idx_d;
         rep_q     <= rep_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
      end
   end

   assign x           = x_q;
   assign x_valid     = x_valid_q;
   assign done        = done_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Bench for serial_seq_tx: table of directed transfers, hand-written handshake and
// reset sequences, then random transfers checked against a bit-queue model.
module tb_serial_seq_tx;

   localparam int WIDTH = 8;
   localparam int LEN_W = 4;
   localparam int REP_W = 4;
   localparam int CNT_W = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             load_valid = 1'b0;
   logic             load_ready;
   logic [WIDTH-1:0] pattern = '0;
   logic [LEN_W-1:0] length = '0;
   logic [REP_W-1:0] repeats = '0;
   logic             abort = 1'b0;
   logic             y;
   logic             x;
   logic             x_valid;
   logic             done;
   logic [CNT_W-1:0] match_count;

   // y source: 0 = random, 1 = overlapping 1010 Mealy detector on x, 2 = always 1
   int   y_mode = 0;
   logic y_rand = 1'b0;
   logic [2:0] hist;

   int n_tests = 0;
   int n_fail  = 0;
   bit exp_q[$];

   typedef struct {
      logic [7:0]  pat;
      logic [3:0]  len;
      logic [3:0]  rep;
      int          abort_at;
      int          mode;
      int          exp_n;
      logic [31:0] exp_bits;
      int          exp_cnt;
   } vec_t;

   vec_t vecs[8];

   logic hs_xv[8]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic hs_x[8]    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic hs_done[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   serial_seq_tx #(
      .WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .CNT_W(CNT_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .pattern     (pattern),
      .length      (length),
      .repeats     (repeats),
      .abort       (abort),
      .y           (y),
      .x           (x),
      .x_valid     (x_valid),
      .done        (done),
      .match_count (match_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock or negedge reset) begin
      if (!reset)        hist <= '0;
      else if (!x_valid) hist <= '0;
      else               hist <= {hist[1:0], x};
   end

   assign y = (y_mode == 1) ? (x_valid && ({hist, x} == 4'b1010)) :
              (y_mode == 2) ? 1'b1 : y_rand;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reference stream: every pass sends pattern[Le-1] down to pattern[0].
   function automatic void build_model(input logic [7:0] pat, input logic [3:0] len,
                                       input logic [3:0] rep, input int abort_at);
      int le;
      le = (len == 0 || int'(len) > WIDTH) ? WIDTH : int'(len);
      exp_q.delete();
      for (int p = 0; p <= int'(rep); p++)
         for (int i = le - 1; i >= 0; i--)
            exp_q.push_back(pat[i]);
      if (abort_at >= 0)
         while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
   endfunction

   // Runs one transfer against exp_q; exp_cnt < 0 means use the hits seen on y.
   task automatic run_transfer(input string tag, input logic [7:0] pat, input logic [3:0] len,
                               input logic [3:0] rep, input int abort_at, input int mode,
                               input int exp_cnt);
      int hits = 0;
      int n    = exp_q.size();
      int c    = 0;
      int want;
      while (!load_ready && c < 20) begin
         step();
         c++;
      end
      check({tag, " load_ready"}, 32'(load_ready), 1);
      y_mode     = mode;
      pattern    = pat;
      length     = len;
      repeats    = rep;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      pattern    = 8'($urandom);
      length     = 4'($urandom);
      repeats    = 4'($urandom);
      for (int k = 0; k < n; k++) begin
         check($sformatf("%s x_valid[%0d]", tag, k), 32'(x_valid), 1);
         check($sformatf("%s x[%0d]", tag, k), 32'(x), 32'(exp_q[k]));
         check($sformatf("%s done[%0d]", tag, k), 32'(done), 0);
         y_rand = 1'($urandom);
         abort  = (k == abort_at);
         #1;
         if (y === 1'b1 && hits < 255) hits++;
         step();
         abort = 1'b0;
      end
      want = (exp_cnt < 0) ? hits : exp_cnt;
      check({tag, " end x_valid"}, 32'(x_valid), 0);
      check({tag, " end x"}, 32'(x), 0);
      check({tag, " end done"}, 32'(done), 1);
      check({tag, " end count"}, 32'(match_count), 32'(want));
      y_rand = 1'($urandom);
      step();
      check({tag, " idle done"}, 32'(done), 0);
      check({tag, " idle ready"}, 32'(load_ready), 1);
      check({tag, " idle x_valid"}, 32'(x_valid), 0);
      check({tag, " idle count"}, 32'(match_count), 32'(want));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got timeout, want completion");
      $fatal(1, "simulation time limit");
   end

   initial begin
      vecs[0] = '{8'hA5, 4'd8,  4'd0, -1, 1, 8, 32'hA5,  1};
      vecs[1] = '{8'h0A, 4'd4,  4'd1, -1, 1, 8, 32'hAA,  3};
      vecs[2] = '{8'h81, 4'd0,  4'd0, -1, 1, 8, 32'h81,  0};
      vecs[3] = '{8'h81, 4'd12, 4'd0, -1, 1, 8, 32'h81,  0};
      vecs[4] = '{8'hFF, 4'd8,  4'd0,  2, 2, 3, 32'h7,   3};
      vecs[5] = '{8'h0A, 4'd4,  4'd1,  5, 1, 6, 32'h2A,  2};
      vecs[6] = '{8'h05, 4'd3,  4'd2, -1, 2, 9, 32'h16D, 9};
      vecs[7] = '{8'h01, 4'd1,  4'd3, -1, 2, 4, 32'hF,   4};

      #1;
      check("reset x", 32'(x), 0);
      check("reset x_valid", 32'(x_valid), 0);
      check("reset done", 32'(done), 0);
      check("reset count", 32'(match_count), 0);
      #22 reset = 1'b1;
      step();
      check("post-reset ready", 32'(load_ready), 1);

      foreach (vecs[v]) begin
         exp_q.delete();
         for (int i = vecs[v].exp_n - 1; i >= 0; i--) exp_q.push_back(vecs[v].exp_bits[i]);
         run_transfer($sformatf("vec%0d", v), vecs[v].pat, vecs[v].len, vecs[v].rep,
                      vecs[v].abort_at, vecs[v].mode, vecs[v].exp_cnt);
      end

      // load_valid held high: 2-cycle gap, and pattern edits mid-transfer are not used
      y_mode     = 0;
      y_rand     = 1'b0;
      pattern    = 8'h02;
      length     = 4'd2;
      repeats    = 4'd0;
      load_valid = 1'b1;
      step();
      for (int k = 0; k < 8; k++) begin
         check($sformatf("hs x_valid[%0d]", k), 32'(x_valid), 32'(hs_xv[k]));
         check($sformatf("hs x[%0d]", k), 32'(x), 32'(hs_x[k]));
         check($sformatf("hs done[%0d]", k), 32'(done), 32'(hs_done[k]));
         if (k == 0) pattern = 8'h01;
         if (k == 4) pattern = 8'h02;
         if (k == 7) load_valid = 1'b0;
         step();
      end
      check("hs settled ready", 32'(load_ready), 1);

      // asynchronous reset during the 4th bit
      y_mode     = 2;
      pattern    = 8'hA5;
      length     = 4'd8;
      repeats    = 4'd0;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      repeat (3) step();
      check("rst pre x_valid", 32'(x_valid), 1);
      check("rst pre count", 32'(match_count), 3);
      #2 reset = 1'b0;
      #1;
      check("rst x", 32'(x), 0);
      check("rst x_valid", 32'(x_valid), 0);
      check("rst done", 32'(done), 0);
      check("rst count", 32'(match_count), 0);
      #1 reset = 1'b1;
      #1;
      check("rst release ready", 32'(load_ready), 1);
      build_model(8'hA5, 4'd8, 4'd0, -1);
      run_transfer("after rst", 8'hA5, 4'd8, 4'd0, -1, 1, 1);

      // random transfers against the queue model
      for (int r = 0; r < 24; r++) begin
         logic [7:0] rp;
         logic [3:0] rl;
         logic [3:0] rr;
         int ab;
         rp = 8'($urandom);
         rl = 4'($urandom);
         rr = 4'($urandom_range(0, 5));
         build_model(rp, rl, rr, -1);
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
         build_model(rp, rl, rr, ab);
         run_transfer($sformatf("rnd%0d", r), rp, rl, rr, ab, 0, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
